uart_tx_cfg: RTL and testbench

//  Runtime-configurable UART transmitter with an input FIFO. Frame format is
//  set per frame: 5..9 data bits, parity none/even/odd, 1 or 2 stop bits, and
//  a 16-bit baud divisor. Sits between the SoC-side byte producer (valid/ready)
//  and the tx pad. It is the successor to the fixed 8N1 transmitter.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_tx_cfg_if.sv | 11 +
 rtl/uart_fifo.sv | 54 +++++
 rtl/uart_tx_cfg.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

    localparam logic [15:0] MIN_DIV = 16'd2;

    // Code 2'b11 is reserved and behaves as no parity.
    function automatic parity_e decode_parity(input logic [1:0] code);
        parity_e p;
        case (code)
            2'b01:   p = PAR_EVEN;
            2'b10:   p = PAR_ODD;
            default: p = PAR_NONE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Producer-side valid/ready byte channel into the UART transmitter.
interface uart_tx_cfg_if #(
    parameter int DATA_W = 9
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO; head word is visible on dout while not empty.
module uart_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= din;
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (level_r == (AW+1)'(DEPTH));
    assign empty = (level_r == (AW+1)'(0));
    assign level = level_r;
endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame data bits, parity, stop bits and baud divisor,
// fed from an input FIFO.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_RST    = 434
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_tx_cfg_if.slave                  in_if,
    input  logic [15:0]                   cfg_baud_div,
    input  logic [3:0]                    cfg_data_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    if (DATA_W < 5 || DATA_W > 9 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        DIV_RST < 2 || DIV_RST > 65535) begin : g_bad_params
        $error("uart_tx_cfg: unsupported parameter set");
    end

    function automatic logic data_parity(input logic [DATA_W-1:0] d, input logic [3:0] n);
        logic p;
        p = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (4'(i) < n) p = p ^ d[i];
            else           p = p;
        end
        return p;
    endfunction

    logic [DATA_W-1:0] fifo_head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              push_s;
    logic              pop_s;
    logic              load_s;
    logic              bit_end_s;
    logic [15:0]       div_in_s;
    logic [3:0]        nbits_in_s;
    parity_e           par_in_s;

    tx_state_e         state_r,    state_nxt_s;
    logic [15:0]       cnt_r,      cnt_nxt_s;
    logic [15:0]       div_r,      div_nxt_s;
    logic [3:0]        nbits_r,    nbits_nxt_s;
    logic [3:0]        bit_idx_r,  bit_idx_nxt_s;
    parity_e           par_r,      par_nxt_s;
    logic              par_bit_r,  par_bit_nxt_s;
    logic              stop2_r,    stop2_nxt_s;
    logic              stop_idx_r, stop_idx_nxt_s;
    logic [DATA_W-1:0] shift_r,    shift_nxt_s;
    logic              tx_r,       tx_nxt_s;

    assign push_s         = in_if.in_valid && !fifo_full_s;
    assign in_if.in_ready = !fifo_full_s;

    uart_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (in_if.in_data),
        .dout  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level)
    );

    assign div_in_s   = (cfg_baud_div < MIN_DIV) ? MIN_DIV : cfg_baud_div;
    assign nbits_in_s = (cfg_data_bits < 4'd5 || cfg_data_bits > 4'(DATA_W)) ?
                        4'(DATA_W) : cfg_data_bits;
    assign par_in_s   = decode_parity(cfg_parity);
    assign bit_end_s  = (cnt_r == 16'd0);

    // Frame sequencing, baud counting and the next tx level.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        div_nxt_s      = div_r;
        nbits_nxt_s    = nbits_r;
        bit_idx_nxt_s  = bit_idx_r;
        par_nxt_s      = par_r;
        par_bit_nxt_s  = par_bit_r;
        stop2_nxt_s    = stop2_r;
        stop_idx_nxt_s = stop_idx_r;
        shift_nxt_s    = shift_r;
        tx_nxt_s       = 1'b1;
        load_s         = 1'b0;
        pop_s          = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (!fifo_empty_s) load_s = 1'b1;
                else               load_s = 1'b0;
            end
            S_START: begin
                tx_nxt_s = 1'b0;
                if (bit_end_s) begin
                    state_nxt_s   = S_DATA;
                    cnt_nxt_s     = div_r - 16'd1;
                    bit_idx_nxt_s = 4'd0;
                end else begin
                    cnt_nxt_s = cnt_r - 16'd1;
                end
            end
            S_DATA: begin
                tx_nxt_s = shift_r[0];
                if (bit_end_s) begin
                    cnt_nxt_s   = div_r - 16'd1;
                    shift_nxt_s = {1'b0, shift_r[DATA_W-1:1]};
                    if (bit_idx_r == nbits_r - 4'd1) begin
                        state_nxt_s    = (par_r == PAR_NONE) ? S_STOP : S_PARITY;
                        stop_idx_nxt_s = 1'b0;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 4'd1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 16'd1;
                end
            end
            S_PARITY: begin
                tx_nxt_s = par_bit_r;
                if (bit_end_s) begin
                    state_nxt_s    = S_STOP;
                    cnt_nxt_s      = div_r - 16'd1;
                    stop_idx_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r - 16'd1;
                end
            end
            S_STOP: begin
                tx_nxt_s = 1'b1;
                if (bit_end_s) begin
                    if (stop2_r && !stop_idx_r) begin
                        stop_idx_nxt_s = 1'b1;
                        cnt_nxt_s      = div_r - 16'd1;
                    end else if (!fifo_empty_s) begin
                        load_s = 1'b1;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 16'd1;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase

        // Starting a frame: take the head word and freeze the config for its duration.
        if (load_s) begin
            pop_s          = 1'b1;
            state_nxt_s    = S_START;
            cnt_nxt_s      = div_in_s - 16'd1;
            div_nxt_s      = div_in_s;
            nbits_nxt_s    = nbits_in_s;
            par_nxt_s      = par_in_s;
            par_bit_nxt_s  = data_parity(fifo_head_s, nbits_in_s) ^ (par_in_s == PAR_ODD);
            stop2_nxt_s    = cfg_stop2;
            stop_idx_nxt_s = 1'b0;
            shift_nxt_s    = fifo_head_s;
        end else begin
            pop_s = 1'b0;
        end
    end

    // State and datapath registers; tx is registered so the pad never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            cnt_r      <= 16'd0;
            div_r      <= MIN_DIV;
            nbits_r    <= 4'(DATA_W);
            bit_idx_r  <= 4'd0;
            par_r      <= PAR_NONE;
            par_bit_r  <= 1'b0;
            stop2_r    <= 1'b0;
            stop_idx_r <= 1'b0;
            shift_r    <= '0;
            tx_r       <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            div_r      <= div_nxt_s;
            nbits_r    <= nbits_nxt_s;
            bit_idx_r  <= bit_idx_nxt_s;
            par_r      <= par_nxt_s;
            par_bit_r  <= par_bit_nxt_s;
            stop2_r    <= stop2_nxt_s;
            stop_idx_r <= stop_idx_nxt_s;
            shift_r    <= shift_nxt_s;
            tx_r       <= tx_nxt_s;
        end
    end

    assign tx   = tx_r;
    assign busy = (state_r != S_IDLE) || !fifo_empty_s;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: expected tx waveforms are built from frame-format rules.
module tb_uart_tx_cfg;
    localparam int DATA_W = 9;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_baud_div;
    logic [3:0]  cfg_data_bits;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    uart_tx_cfg_if #(.DATA_W(DATA_W)) bus ();

    uart_tx_cfg #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .DIV_RST(434)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_if         (bus),
        .cfg_baud_div  (cfg_baud_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .tx            (tx),
        .busy          (busy),
        .fifo_level    (fifo_level)
    );

    // Append one frame, one entry per clock cycle, to the expected tx stream.
    task automatic add_frame(input logic [8:0] d, input int nb_cfg, input int par_cfg,
                             input bit s2, input int div_cfg);
        int nb = (nb_cfg < 5 || nb_cfg > DATA_W) ? DATA_W : nb_cfg;
        int dv = (div_cfg < 2) ? 2 : div_cfg;
        bit bits[$];
        bit p = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            bits.push_back(d[i]);
            p = p ^ d[i];
        end
        if (par_cfg == 1) bits.push_back(p);
        else if (par_cfg == 2) bits.push_back(!p);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[j])
            for (int k = 0; k < dv; k++) exp_q.push_back(bits[j]);
    endtask

    task automatic set_cfg(input int div, input int nb, input int par, input bit s2);
        cfg_baud_div  = 16'(div);
        cfg_data_bits = 4'(nb);
        cfg_parity    = 2'(par);
        cfg_stop2     = s2;
    endtask

    // Present words on consecutive edges (first edge = E0) and compare tx against exp_q from E2.
    task automatic run_stream(input logic [8:0] words[$], input int n_accept, input int switch_bits);
        fork
            begin
                for (int k = 0; k < words.size(); k++) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = words[k];
                    checks++;
                    if (bus.in_ready !== (k < n_accept)) begin
                        errors++;
                        $display("FAIL in_ready[%0d] got %b want %b", k, bus.in_ready, (k < n_accept));
                    end
                    @(negedge clk);
                end
                if (words.size() > n_accept) begin
                    checks++;
                    if (fifo_level !== 3'(DEPTH) || bus.in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL full_state got level=%0d ready=%b want level=%0d ready=0",
                                 fifo_level, bus.in_ready, DEPTH);
                    end
                end
                bus.in_valid = 1'b0;
                bus.in_data  = 9'($urandom);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                checks++;
                if (tx !== 1'b1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL latency_e1 got tx=%b busy=%b want tx=1 busy=1", tx, busy);
                end
                foreach (exp_q[i]) begin
                    @(negedge clk);
                    checks++;
                    if (tx !== exp_q[i]) begin
                        errors++;
                        $display("FAIL tx_stream[%0d] got %b want %b", i, tx, exp_q[i]);
                    end
                end
                @(negedge clk);
                checks++;
                if (tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0) begin
                    errors++;
                    $display("FAIL frame_end got tx=%b busy=%b level=%0d want tx=1 busy=0 level=0",
                             tx, busy, fifo_level);
                end
            end
            begin
                if (switch_bits >= 0) begin
                    @(negedge clk);
                    @(negedge clk);
                    cfg_data_bits = 4'(switch_bits);
                end
            end
        join
    endtask

    task automatic single(input logic [8:0] d, input int div, input int nb, input int par, input bit s2);
        logic [8:0] w[$];
        w.push_back(d);
        set_cfg(div, nb, par, s2);
        exp_q.delete();
        add_frame(d, nb, par, s2, div);
        run_stream(w, 1, -1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset got tx=%b busy=%b level=%0d ready=%b want 1 0 0 1",
                     tx, busy, fifo_level, bus.in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_formats();
        single(9'h055, 4, 8, 0, 1'b0);
        single(9'h041, 3, 7, 1, 1'b0);
        single(9'h0FF, 2, 8, 2, 1'b1);
        single(9'h1A3, 2, 9, 1, 1'b0);
        single(9'h1F5, 3, 5, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [8:0] w[$];
        set_cfg(16, 8, 0, 1'b0);
        exp_q.delete();
        for (int i = 0; i < 6; i++) w.push_back(9'($urandom));
        for (int i = 0; i < 5; i++) add_frame(w[i], 8, 0, 1'b0, 16);
        run_stream(w, 5, -1);
    endtask

    task automatic test_cfg_change();
        logic [8:0] w[$];
        w.push_back(9'h0A5);
        w.push_back(9'h1F3);
        set_cfg(0, 8, 0, 1'b0);
        exp_q.delete();
        add_frame(w[0], 8, 0, 1'b0, 0);
        add_frame(w[1], 5, 0, 1'b0, 0);
        run_stream(w, 2, 5);
    endtask

    task automatic test_reset_midframe();
        set_cfg(4, 8, 0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 9'h0C3;
        @(negedge clk);
        bus.in_data  = 9'h03C;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL level_before_rst got %0d want 1", fifo_level);
        end
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midframe_rst got tx=%b busy=%b level=%0d ready=%b want 1 0 0 1",
                     tx, busy, fifo_level, bus.in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        single(9'h05A, 4, 8, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++)
            single(9'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 9'd0;
        set_cfg(4, 8, 0, 1'b0);
        @(negedge clk);
        test_reset();
        test_formats();
        test_back_to_back();
        test_cfg_change();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
